// File: rtl/lookahead_acc_pkg.sv
// Shared types and constants for the lookahead accumulator.
// State encoding and lookahead group size.
package lookahead_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int LA_GROUP = 2;

endpackage

// File: rtl/la_add_slice.sv
// N-bit adder from 2-bit lookahead groups; group carries ripple.
// Exposes carry-out and carry into the MSB for overflow detection.
module la_add_slice
  import lookahead_acc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  localparam int G = N / LA_GROUP;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;
  logic [G:0]   gc;

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = cin;

  for (genvar i = 0; i < G; i++) begin : grp
    localparam int B = i * LA_GROUP;
    assign c[B]    = gc[i];
    assign c[B+1]  = g[B] | (p[B] & gc[i]);
    assign gc[i+1] = g[B+1]
                   | (p[B+1] & g[B])
                   | (p[B+1] & p[B] & gc[i]);
  end

  assign sum  = p ^ c;
  assign cout = gc[G];
  assign cmsb = c[N-1];

endmodule

// File: rtl/lookahead_accumulator.sv
// Streaming signed accumulator; high half trails low half by one
// cycle so one operand is accepted per cycle.
module lookahead_accumulator
  import lookahead_acc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sub,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf
);

  localparam int LO = ACC_WIDTH / 2;

  state_t state;

  logic [LO-1:0] acc_lo;
  logic [LO-1:0] acc_hi;
  logic [LO-1:0] op_hi_r;
  logic          c_lo_r;
  logic          ovf_sticky;

  logic signed [ACC_WIDTH-1:0] op;
  logic [ACC_WIDTH-1:0]        opx;
  logic [LO-1:0]               lo_sum;
  logic                        c_lo;
  logic                        lo_msb_unused;
  logic [LO-1:0]               hi_next;
  logic                        hi_cout;
  logic                        hi_cmsb;
  logic                        ovf_now;

  assign op       = ACC_WIDTH'($signed(in_data));
  assign opx      = in_sub ? ~op : op;
  assign in_ready = (state == ACCUM);
  assign ovf_now  = hi_cout ^ hi_cmsb;

  la_add_slice #(.N(LO)) u_lo (
    .a    (acc_lo),
    .b    (opx[LO-1:0]),
    .cin  (in_sub),
    .sum  (lo_sum),
    .cout (c_lo),
    .cmsb (lo_msb_unused)
  );

  la_add_slice #(.N(LO)) u_hi (
    .a    (acc_hi),
    .b    (op_hi_r),
    .cin  (c_lo_r),
    .sum  (hi_next),
    .cout (hi_cout),
    .cmsb (hi_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      acc_lo     <= '0;
      acc_hi     <= '0;
      op_hi_r    <= '0;
      c_lo_r     <= 1'b0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          // idle cycles feed zero into the high half
          acc_hi     <= hi_next;
          ovf_sticky <= ovf_sticky | ovf_now;
          if (in_valid) begin
            acc_lo  <= lo_sum;
            op_hi_r <= opx[ACC_WIDTH-1:LO];
            c_lo_r  <= c_lo;
            if (in_last) state <= DRAIN;
          end else begin
            op_hi_r <= '0;
            c_lo_r  <= 1'b0;
          end
        end
        DRAIN: begin
          out_data   <= {hi_next, acc_lo};
          out_ovf    <= ovf_sticky | ovf_now;
          out_valid  <= 1'b1;
          acc_lo     <= '0;
          acc_hi     <= '0;
          op_hi_r    <= '0;
          c_lo_r     <= 1'b0;
          ovf_sticky <= 1'b0;
          state      <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_lookahead_accumulator.sv
// Self-checking bench for lookahead_accumulator.
// Reference model: integer running sum with range-based overflow.
module tb_lookahead_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sub;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lookahead_accumulator #(.WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  // model: s is the wrapped signed sum, ovf sticky
  task automatic model_step(inout int s, inout bit ovf,
                            input logic [7:0] d, input logic sub);
    int v, t;
    v = int'($signed(d));
    t = sub ? s - v : s + v;
    if (t > 32767 || t < -32768) ovf = 1'b1;
    s = int'($signed(t[15:0]));
  endtask

  task automatic send(input logic [7:0] d, input logic sub,
                      input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sub   = 1'b0;
  endtask

  task automatic wait_out(output int n, output bit to);
    n  = 0;
    to = 1'b0;
    while (!out_valid) begin
      if (n >= 50) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_out_data got=%h want=0000", out_data);
    end
    checks++;
    if (out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_ovf got=%b want=0", out_ovf);
    end
  endtask

  task automatic test_basic_add;
    int n;
    bit to;
    out_ready = 1'b1;
    send(8'd100, 1'b0, 1'b0);
    send(8'd27, 1'b0, 1'b0);
    send(8'hFB, 1'b0, 1'b1);
    wait_out(n, to);
    checks++;
    if (to || n != 1) begin
      errors++;
      $display("FAIL basic_latency got=%0d want=1 timeout=%0b", n, to);
    end
    checks++;
    if (out_data !== 16'h007A) begin
      errors++;
      $display("FAIL basic_data got=%h want=007a", out_data);
    end
    checks++;
    if (out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf got=%b want=0", out_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake got valid=%b ready=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_subtract;
    int n;
    bit to;
    send(8'd10, 1'b0, 1'b0);
    send(8'd30, 1'b1, 1'b1);
    wait_out(n, to);
    checks++;
    if (to || out_data !== 16'hFFEC) begin
      errors++;
      $display("FAIL sub_data got=%h want=ffec timeout=%0b", out_data, to);
    end
    checks++;
    if (out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_ovf got=%b want=0", out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cross_carry;
    int n;
    bit to;
    send(8'd127, 1'b0, 1'b0);
    send(8'd127, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b1);
    wait_out(n, to);
    checks++;
    if (to || out_data !== 16'h0100) begin
      errors++;
      $display("FAIL carry_data got=%h want=0100 timeout=%0b", out_data, to);
    end
    checks++;
    if (out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_ovf got=%b want=0", out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int n;
    bit to;
    for (int i = 0; i < 259; i++) send(8'd127, 1'b0, i == 258);
    wait_out(n, to);
    checks++;
    if (to || out_data !== 16'h807D) begin
      errors++;
      $display("FAIL ovf_data got=%h want=807d timeout=%0b", out_data, to);
    end
    checks++;
    if (out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got=%b want=1", out_ovf);
    end
    @(posedge clk); #1;
    send(8'd1, 1'b0, 1'b1);
    wait_out(n, to);
    checks++;
    if (to || out_data !== 16'h0001) begin
      errors++;
      $display("FAIL ovf_next_data got=%h want=0001", out_data);
    end
    checks++;
    if (out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_next_flag got=%b want=0", out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int n;
    bit to;
    logic [15:0] held;
    out_ready = 1'b0;
    send(8'd40, 1'b0, 1'b0);
    send(8'd3, 1'b1, 1'b1);
    wait_out(n, to);
    held = out_data;
    checks++;
    if (to || held !== 16'h0025) begin
      errors++;
      $display("FAIL bp_data got=%h want=0025", held);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
        errors++;
        $display("FAIL bp_hold got v=%b r=%b d=%h want 1 0 %h",
                 out_valid, in_ready, out_data, held);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    send(8'd3, 1'b0, 1'b1);
    wait_out(n, to);
    checks++;
    if (to || out_data !== 16'h0003 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got=%h/%b want=0003/0", out_data, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame;
    int n;
    bit to;
    send(8'd50, 1'b0, 1'b0);
    send(8'd60, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_data !== 16'h0000 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got r=%b v=%b d=%h o=%b want 1 0 0000 0",
               in_ready, out_valid, out_data, out_ovf);
    end
    send(8'd7, 1'b0, 1'b1);
    wait_out(n, to);
    checks++;
    if (to || out_data !== 16'h0007 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_data got=%h/%b want=0007/0", out_data, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int n, len, s;
    bit to, ovf;
    logic [7:0] d;
    logic sub;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 12);
      s = 0;
      ovf = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        d   = 8'($urandom);
        sub = 1'($urandom);
        model_step(s, ovf, d, sub);
        send(d, sub, k == len - 1);
      end
      wait_out(n, to);
      checks++;
      if (to || out_data !== 16'(s)) begin
        errors++;
        $display("FAIL rand_data frame=%0d got=%h want=%h", f, out_data, 16'(s));
      end
      checks++;
      if (out_ovf !== ovf) begin
        errors++;
        $display("FAIL rand_ovf frame=%0d got=%b want=%b", f, out_ovf, ovf);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    // force an overflowing frame through the random path too
    s = 0;
    ovf = 1'b0;
    for (int k = 0; k < 300; k++) begin
      d = 8'h80;
      model_step(s, ovf, d, 1'b0);
      send(d, 1'b0, k == 299);
    end
    wait_out(n, to);
    checks++;
    if (to || out_data !== 16'(s) || out_ovf !== ovf) begin
      errors++;
      $display("FAIL rand_neg_ovf got=%h/%b want=%h/%b",
               out_data, out_ovf, 16'(s), ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_basic_add;
    test_subtract;
    test_cross_carry;
    test_overflow;
    test_backpressure;
    test_reset_mid_frame;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lookahead_accumulator.md
# lookahead_accumulator

Streaming signed accumulator for the subarray MAC output path. It consumes the partial products whose carries the lookahead carry logic generates, and adds or subtracts each one into a running sum. The adder is split into a low half and a high half, each built from 2-bit lookahead groups, and the high half trails the low half by one cycle, so one operand is accepted every cycle. A frame ends with an operand flagged `in_last`; the total is then presented on a valid/ready output with a sticky overflow flag.

## Interface
- `WIDTH`, 8: operand width, two's complement, even.
- `ACC_WIDTH`, 16: accumulator width, multiple of 4, ≥ `WIDTH`. The low half is `ACC_WIDTH/2` bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: block can accept an operand.
- `in_data` in `WIDTH`: signed operand.
- `in_sub` in 1: 1 subtracts the operand, 0 adds it.
- `in_last` in 1: final operand of the frame.
- `out_valid` out 1: frame result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out `ACC_WIDTH`: signed frame sum.
- `out_ovf` out 1: signed overflow occurred somewhere in the frame.

## Operation
- Transfers occur on `valid && ready` at the rising edge.
- Operand preparation:
  - `op = sext(in_data)` to `ACC_WIDTH`.
  - For subtract, use `~op` with carry-in 1; for add, carry-in 0.
- Low-half update, at the acceptance edge:
  - `{c_lo, acc_lo} <= acc_lo + op_lo + cin`.
  - `op_hi` and `c_lo` are registered into the stage-2 registers.
- High-half update, at the following edge: `acc_hi <= acc_hi + op_hi_r + c_lo_r`.
- Because the high half of operand N and the low half of operand N+1 update on the same edge, back-to-back operands need no stall.
- Overflow detection is at the high-half update: carry into the MSB differs from carry out of the MSB. `ovf_sticky` is set and stays set until the frame is cleared.
- All adders are built from 2-bit group generate/propagate terms; group carries ripple within each half.
- Results wrap modulo 2^`ACC_WIDTH`.
- State machine:
  - ACCUM: `in_ready`=1. An accepted `in_last` moves to DRAIN.
  - DRAIN, one cycle: `in_ready`=0. The pending high half completes. `out_data <= {acc_hi_next, acc_lo}` and `out_ovf <= ovf_sticky | ovf_now`. Accumulator, stage-2 registers and sticky flag clear to 0. Moves to HOLD.
  - HOLD: `out_valid`=1 and `in_ready`=0. `out_data` and `out_ovf` stay stable. On `out_ready` the block moves to ACCUM with `out_valid`=0 on the next cycle.
- A stray `in_valid` during DRAIN or HOLD is ignored; it is not accepted.
- The first operand of a new frame starts from a zero accumulator.

## Timing
- Reset values:
  - State is ACCUM, so `in_ready`=1.
  - `out_valid`=0, `out_data`=0, `out_ovf`=0.
  - `acc_lo`=0, `acc_hi`=0; stage-2 registers and `ovf_sticky` are 0.
- Latency: `in_last` accepted at edge E0 → `out_valid` high from the cycle after E1 (2 cycles).
- Throughput: 1 operand per cycle inside a frame. Minimum gap between frames is 2 cycles (DRAIN plus one HOLD cycle when `out_ready`=1).
- `in_ready` depends only on state registers, not combinationally on `in_valid`.
- A single-operand frame (first operand has `in_last`) is legal and gives result = ±operand.
- Reset during any state:
  - The in-flight high-half update is discarded.
  - The partial frame is lost.
  - `out_valid` drops at that edge.

## Structure
- Shared package `lookahead_acc_pkg`:
  - state encoding ACCUM=0, DRAIN=1, HOLD=2.
  - lookahead group size constant `LA_GROUP=2`.
- Sub-module `la_add_slice`: parameterized N-bit adder with carry-in, carry-out and MSB carry-in, built from 2-bit lookahead groups. Instantiated twice, once for the low half and once for the high half.
- Top level holds the FSM, operand preparation, the pipeline registers and the output register.

## Test plan
All scenarios use `WIDTH`=8, `ACC_WIDTH`=16.
- **Basic add:** +100, +27, then −5 with `in_last`, back-to-back with `out_ready`=1 → `out_data`=0x007A (122), `out_ovf`=0, `out_valid` 2 cycles after the last acceptance.
- **Subtract:** +10 (add), then 30 with `in_sub`=1 and `in_last` → `out_data`=0xFFEC (−20), `out_ovf`=0.
- **Cross-half carry, back-to-back:** +127, +127, then +2 with `in_last` → `out_data`=0x0100. This checks `c_lo` propagation while the next low half updates on the same edge.
- **Overflow:** 259 consecutive +127 operands, the last with `in_last` → `out_data`=0x807D, `out_ovf`=1. The next frame of a single +1 → `out_data`=0x0001, `out_ovf`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in HOLD → `out_data` stable, `in_ready`=0, `in_valid` pulses ignored. Release → exactly one handshake, then ACCUM from 0.
- **Reset mid-frame:** accept +50, +60, assert `rst` one cycle, then feed +7 with `in_last` → `out_data`=0x0007. All outputs read their reset values in the cycle after `rst`.
